// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: shares the register-file write port between pipeline writeback and a one-entry MDU skid buffer.
module rf_wb_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wb_valid,
  input  logic [4:0]  wb_rd,
  input  logic [63:0] wb_wd,
  output logic        wb_stall,
  input  logic        mdu_valid,
  input  logic [4:0]  mdu_rd,
  input  logic [63:0] mdu_data,
  output logic        mdu_ready,
  output logic        rf_we,
  output logic [4:0]  rf_wa,
  output logic [63:0] rf_wd,
  output logic        buf_valid,
  output logic [4:0]  buf_rd,
  output logic [31:0] stall_cycles
);
  localparam int AW = STARVE_LIMIT < 1 ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [AW-1:0] LIM = AW'(STARVE_LIMIT);
  typedef enum logic {EMPTY, FULL} state_t;
  state_t          state;
  logic [63:0]     buf_data;
  logic [AW-1:0]   age;
  logic            wb_req, grant_buf, accept;
  assign buf_valid = state == FULL;
  assign wb_req    = wb_valid & (wb_rd != 5'd0);
  // age saturates at LIM, so equality is the starvation test
  assign grant_buf = buf_valid & (!wb_req | age == LIM);
  assign wb_stall  = wb_req & grant_buf;
  assign mdu_ready = !buf_valid | grant_buf;
  assign accept    = mdu_valid & mdu_ready;
  assign rf_we     = grant_buf ? buf_rd != 5'd0 : wb_req;
  assign rf_wa     = grant_buf ? buf_rd : wb_rd;
  assign rf_wd     = grant_buf ? buf_data : wb_wd;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= EMPTY;
      buf_rd       <= 5'd0;
      buf_data     <= 64'd0;
      age          <= '0;
      stall_cycles <= 32'd0;
    end else begin
      if (accept) begin
        state    <= FULL;
        buf_rd   <= mdu_rd;
        buf_data <= mdu_data;
        age      <= '0;
      end else if (grant_buf) begin
        state <= EMPTY;
      end else if (buf_valid && age != LIM) begin
        age <= age + 1'b1;
      end
      if (wb_stall && stall_cycles != 32'hFFFF_FFFF)
        stall_cycles <= stall_cycles + 32'd1;
    end
  end
endmodule
